serializer_mlane: RTL and testbench

SERIALIZER_MLANE -- requirements
Module: serializer_mlane

---
 rtl/serializer_mlane.sv | 188 ++++++++++++++++++
 tb/tb_serializer_mlane.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_mlane.sv
// serializer_mlane
//   Converts parallel words of up to DATA_W bits into a stream of beats of
//   LANES bits each. Each word carries its own length (data_mod_i, where 0
//   means a full DATA_W-bit word). The storage is a shift register for the
//   word currently being transmitted plus a single holding register, so a
//   second word can be queued while the first one is still going out. The
//   queued word follows the previous word's last beat with no idle cycle.
//
// Parameters
//   DATA_W    parallel word width in bits
//   LANES     bits per beat (DATA_W must be a multiple of LANES)
//   MSB_FIRST 1: send data_i[DATA_W-1] first, 0: send data_i[0] first
//   MOD_W     width of the length field
//
// Ports
//   clk_i          in   clock, all state changes on the rising edge
//   arst_i         in   asynchronous active-high reset
//   data_i         in   parallel word to serialize
//   data_mod_i     in   number of valid bits (0 = DATA_W)
//   data_val_i     in   input word valid
//   data_rdy_o     out  a word can be accepted this cycle
//   ser_data_o     out  current beat, lane LANES-1 holds the earliest bit
//   ser_mask_o     out  per-lane valid flags of the current beat
//   ser_data_val_o out  beat valid
//   ser_last_o     out  current beat is the final beat of its word
//   busy_o         out  a beat is being presented or a word is held
module serializer_mlane #(
  parameter int DATA_W    = 16,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 1,
  parameter int MOD_W     = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              data_rdy_o,
  output logic [LANES-1:0]  ser_data_o,
  output logic [LANES-1:0]  ser_mask_o,
  output logic              ser_data_val_o,
  output logic              ser_last_o,
  output logic              busy_o
);

  localparam int BEATS_MAX = DATA_W / LANES;
  localparam int CNT_W     = $clog2(BEATS_MAX) + 1;

  // Word length in bits; 0 (and anything out of range) means a full word,
  // which keeps the beat counter from ever exceeding BEATS_MAX.
  function automatic logic [31:0] len_of(input logic [MOD_W-1:0] m);
    logic [31:0] len;
    len = 32'(m);
    if (len == 32'd0 || len > 32'(DATA_W)) begin
      len = 32'(DATA_W);
    end
    return len;
  endfunction

  // ceil(L / LANES)
  function automatic logic [CNT_W-1:0] beats_of(input logic [MOD_W-1:0] m);
    logic [31:0] len;
    len = len_of(m);
    return CNT_W'((len + 32'(LANES) - 32'd1) / 32'(LANES));
  endfunction

  // Final-beat mask: the top (L mod LANES) lanes, or every lane when the
  // word is a whole number of beats.
  function automatic logic [LANES-1:0] mask_of(input logic [MOD_W-1:0] m);
    logic [31:0] rem;
    rem = len_of(m) % 32'(LANES);
    if (rem == 32'd0) begin
      return {LANES{1'b1}};
    end
    return ~({LANES{1'b1}} >> rem);
  endfunction

  // Words are stored "earliest bit at the MSB" regardless of MSB_FIRST, so
  // the shifter always emits its top LANES bits and shifts left. For LSB
  // first transmission the word is bit-reversed on the way in.
  logic [DATA_W-1:0] data_norm;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign data_norm = data_i;
    end else begin : g_lsb_first
      for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rev
        assign data_norm[gi] = data_i[DATA_W-1-gi];
      end
    end
  endgenerate

  // Shifter: word in flight, beats still to present (0 = idle), and the
  // lane mask to apply on its final beat.
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]  beats_reg, beats_next;
  logic [LANES-1:0]  last_mask_reg, last_mask_next;

  // Holding register: one queued word with its precomputed beat count/mask.
  logic [DATA_W-1:0] hold_data_reg, hold_data_next;
  logic [CNT_W-1:0]  hold_beats_reg, hold_beats_next;
  logic [LANES-1:0]  hold_mask_reg, hold_mask_next;
  logic              hold_full_reg, hold_full_next;

  logic              accept;
  logic              active;
  logic              final_beat;
  logic [CNT_W-1:0]  in_beats;
  logic [LANES-1:0]  in_mask;
  logic [LANES-1:0]  beat_bits;

  assign in_beats   = beats_of(data_mod_i);
  assign in_mask    = mask_of(data_mod_i);
  assign accept     = data_val_i && !hold_full_reg;
  assign active     = (beats_reg != '0);
  assign final_beat = (beats_reg == CNT_W'(1));

  always_comb begin
    shift_next      = shift_reg;
    beats_next      = beats_reg;
    last_mask_next  = last_mask_reg;
    hold_data_next  = hold_data_reg;
    hold_beats_next = hold_beats_reg;
    hold_mask_next  = hold_mask_reg;
    hold_full_next  = hold_full_reg;

    if (!active || final_beat) begin
      // Shifter is free after this edge: refill it so the next word's first
      // beat directly follows the current last beat.
      if (hold_full_reg) begin
        shift_next     = hold_data_reg;
        beats_next     = hold_beats_reg;
        last_mask_next = hold_mask_reg;
        hold_full_next = 1'b0;
      end else if (accept) begin
        shift_next     = data_norm;
        beats_next     = in_beats;
        last_mask_next = in_mask;
      end else begin
        shift_next     = '0;
        beats_next     = '0;
        last_mask_next = '0;
      end
    end else begin
      shift_next = shift_reg << LANES;
      beats_next = beats_reg - CNT_W'(1);
      if (accept) begin
        hold_data_next  = data_norm;
        hold_beats_next = in_beats;
        hold_mask_next  = in_mask;
        hold_full_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      shift_reg      <= '0;
      beats_reg      <= '0;
      last_mask_reg  <= '0;
      hold_data_reg  <= '0;
      hold_beats_reg <= '0;
      hold_mask_reg  <= '0;
      hold_full_reg  <= 1'b0;
    end else begin
      shift_reg      <= shift_next;
      beats_reg      <= beats_next;
      last_mask_reg  <= last_mask_next;
      hold_data_reg  <= hold_data_next;
      hold_beats_reg <= hold_beats_next;
      hold_mask_reg  <= hold_mask_next;
      hold_full_reg  <= hold_full_next;
    end
  end

  // Outputs are decoded straight from the registers, so an asynchronous
  // reset forces them to their idle values immediately.
  assign beat_bits      = shift_reg[DATA_W-1 -: LANES];
  assign ser_data_val_o = active;
  assign ser_last_o     = final_beat;
  assign ser_mask_o     = !active    ? '0 :
                          final_beat ? last_mask_reg : {LANES{1'b1}};
  // Masked lanes are forced to 0 so bits beyond the word length never leak.
  assign ser_data_o     = beat_bits & ser_mask_o;
  assign data_rdy_o     = !hold_full_reg;
  assign busy_o         = active || hold_full_reg;

endmodule

// File: tb/tb_serializer_mlane.sv
module tb_serializer_mlane;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] m;
    logic       l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst;
  logic [15:0] din  [3];
  logic [3:0]  dmod [3];
  logic [2:0]  dval;

  logic rdy0, rdy1, rdy2, sval0, sval1, sval2;
  logic slast0, slast1, slast2, busy0, busy1, busy2;
  logic a_sd, a_sm, c_sd, c_sm;
  logic [3:0] b_sd, b_sm;
  logic [2:0] rdy, sval, slast, busy;

  assign rdy   = {rdy2, rdy1, rdy0};
  assign sval  = {sval2, sval1, sval0};
  assign slast = {slast2, slast1, slast0};
  assign busy  = {busy2, busy1, busy0};

  int checks = 0;
  int errors = 0;
  int last_tries = 0;
  beat_t q0[$];
  beat_t q1[$];
  beat_t q2[$];

  // DUT 0: defaults (1 lane, MSB first)
  serializer_mlane dut_a (
    .clk_i(clk), .arst_i(arst), .data_i(din[0]), .data_mod_i(dmod[0]),
    .data_val_i(dval[0]), .data_rdy_o(rdy0), .ser_data_o(a_sd),
    .ser_mask_o(a_sm), .ser_data_val_o(sval0), .ser_last_o(slast0),
    .busy_o(busy0)
  );

  // DUT 1: 4 lanes, MSB first
  serializer_mlane #(.DATA_W(16), .LANES(4), .MSB_FIRST(1)) dut_b (
    .clk_i(clk), .arst_i(arst), .data_i(din[1]), .data_mod_i(dmod[1]),
    .data_val_i(dval[1]), .data_rdy_o(rdy1), .ser_data_o(b_sd),
    .ser_mask_o(b_sm), .ser_data_val_o(sval1), .ser_last_o(slast1),
    .busy_o(busy1)
  );

  // DUT 2: 1 lane, LSB first
  serializer_mlane #(.DATA_W(16), .LANES(1), .MSB_FIRST(0)) dut_c (
    .clk_i(clk), .arst_i(arst), .data_i(din[2]), .data_mod_i(dmod[2]),
    .data_val_i(dval[2]), .data_rdy_o(rdy2), .ser_data_o(c_sd),
    .ser_mask_o(c_sm), .ser_data_val_o(sval2), .ser_last_o(slast2),
    .busy_o(busy2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic push_beat(input int w, input logic [3:0] d, input logic [3:0] m, input logic l);
    beat_t b;
    b.d = d; b.m = m; b.l = l;
    case (w)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  // Expected serial stream, right-aligned: bit n-1 goes out first.
  task automatic push_bits(input int w, input logic [15:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      push_beat(w, {3'b000, pat[i]}, 4'b0001, (i == 0));
    end
  endtask

  function automatic int qsize(input int w);
    case (w)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic beat_t qpop(input int w);
    case (w)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic mon(input int w, input logic [3:0] d, input logic [3:0] m,
                     input logic v, input logic l);
    beat_t e;
    checks++;
    if (v) begin
      if (qsize(w) == 0) begin
        errors++;
        $display("FAIL unexpected_beat dut%0d got data=%h mask=%h last=%b required no beat",
                 w, d, m, l);
      end else begin
        e = qpop(w);
        if ({d, m, l} !== {e.d, e.m, e.l}) begin
          errors++;
          $display("FAIL beat dut%0d got data=%h mask=%h last=%b required data=%h mask=%h last=%b",
                   w, d, m, l, e.d, e.m, e.l);
        end else begin
          $display("beat dut%0d data=%h mask=%h last=%b ok", w, d, m, l);
        end
      end
    end else if (d !== 4'h0 || m !== 4'h0 || l !== 1'b0) begin
      errors++;
      $display("FAIL idle_zero dut%0d got data=%h mask=%h last=%b required 0/0/0", w, d, m, l);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    mon(0, {3'b000, a_sd}, {3'b000, a_sm}, sval0, slast0);
    mon(1, b_sd, b_sm, sval1, slast1);
    mon(2, {3'b000, c_sd}, {3'b000, c_sm}, sval2, slast2);
  end

  // Offer a word, wait for acceptance, then count contiguous valid beats
  // starting right after the accepting edge.
  task automatic offer_run(input int w, input logic [15:0] d, input logic [3:0] m,
                           input int exp_beats, input string name);
    logic acc;
    int cnt;
    acc = 1'b0;
    last_tries = 0;
    din[w] = d; dmod[w] = m; dval[w] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      acc = rdy[w];
      last_tries++;
      @(posedge clk); #1;
      if (acc) break;
    end
    dval[w] = 1'b0;
    chk({name, "_accept"}, {31'd0, acc}, 32'd1);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!sval[w]) break;
      cnt++;
      @(posedge clk); #1;
    end
    chk({name, "_beats"}, cnt, exp_beats);
    chk({name, "_idle_busy"}, {31'd0, busy[w]}, 32'd0);
    $display("word dut%0d %s data=%h mod=%0d beats=%0d", w, name, d, m, cnt);
  endtask

  int vcount;

  initial begin
    arst = 1'b1;
    dval = 3'b000;
    for (int i = 0; i < 3; i++) begin
      din[i] = 16'h0;
      dmod[i] = 4'h0;
    end
    #3;
    chk("rst_rdy", {29'd0, rdy}, 32'h7);
    chk("rst_val", {29'd0, sval}, 32'h0);
    chk("rst_busy", {29'd0, busy}, 32'h0);
    chk("rst_last", {29'd0, slast}, 32'h0);
    @(posedge clk); #1;
    arst = 1'b0;

    // Full 16-bit word, accepted on the first edge after reset release.
    push_bits(0, 16'b1010010111000011, 16);
    offer_run(0, 16'hA5C3, 4'd0, 16, "a5c3_full");
    chk("a5c3_first_edge", last_tries, 1);

    // One-bit word.
    push_bits(0, 16'b1, 1);
    offer_run(0, 16'h8000, 4'd1, 1, "msb_mod1");

    // Back-to-back: A, then B accepted at the end of A beat 2, C ignored.
    push_bits(0, 16'b0001001000110100, 16);
    din[0] = 16'h1234; dmod[0] = 4'd0; dval[0] = 1'b1;
    chk("b2b_rdy_a", {31'd0, rdy[0]}, 32'd1);
    @(posedge clk); #1;
    dval[0] = 1'b0;
    vcount = 0;
    for (int c = 1; c <= 32; c++) begin
      if (sval[0]) vcount++;
      if (c == 2) begin
        chk("b2b_rdy_b", {31'd0, rdy[0]}, 32'd1);
        push_bits(0, 16'b1011111011101111, 16);
        din[0] = 16'hBEEF; dval[0] = 1'b1;
      end
      if (c == 3) begin
        chk("b2b_held_rdy", {31'd0, rdy[0]}, 32'd0);
        chk("b2b_held_busy", {31'd0, busy[0]}, 32'd1);
        din[0] = 16'hFFFF; dval[0] = 1'b1;
      end
      if (c == 5) dval[0] = 1'b0;
      if (c == 16) chk("b2b_rdy_until_load", {31'd0, rdy[0]}, 32'd0);
      if (c == 17) chk("b2b_rdy_after_load", {31'd0, rdy[0]}, 32'd1);
      @(posedge clk); #1;
    end
    chk("b2b_contiguous", vcount, 32);
    chk("b2b_end_val", {31'd0, sval[0]}, 32'd0);

    // Four lanes.
    push_beat(1, 4'hA, 4'hF, 1'b0);
    push_beat(1, 4'b0100, 4'b1100, 1'b1);
    offer_run(1, 16'hA5C3, 4'd6, 2, "l4_mod6");
    push_beat(1, 4'h1, 4'hF, 1'b0);
    push_beat(1, 4'h2, 4'hF, 1'b0);
    push_beat(1, 4'h3, 4'hF, 1'b0);
    push_beat(1, 4'h4, 4'hF, 1'b1);
    offer_run(1, 16'h1234, 4'd0, 4, "l4_full");
    push_beat(1, 4'hF, 4'hF, 1'b0);
    push_beat(1, 4'b1000, 4'b1000, 1'b1);
    offer_run(1, 16'hFFFF, 4'd5, 2, "l4_mod5");
    push_beat(1, 4'hC, 4'hF, 1'b1);
    offer_run(1, 16'hC000, 4'd4, 1, "l4_mod4");

    // LSB first.
    push_bits(2, 16'b100, 3);
    offer_run(2, 16'h0001, 4'd3, 3, "lsb_mod3");
    push_bits(2, 16'b0000000000000001, 16);
    offer_run(2, 16'h8000, 4'd0, 16, "lsb_full");
    push_bits(2, 16'b10100, 5);
    offer_run(2, 16'h00C5, 4'd5, 5, "lsb_mod5");

    // Reset during beat 5 of X with Y held.
    for (int i = 0; i < 4; i++) push_beat(0, 4'h1, 4'h1, 1'b0);
    din[0] = 16'hF0F0; dmod[0] = 4'd0; dval[0] = 1'b1;
    @(posedge clk); #1;
    din[0] = 16'h5555;
    @(posedge clk); #1;
    dval[0] = 1'b0;
    chk("rst_test_held_rdy", {31'd0, rdy[0]}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst_test_beat5_val", {31'd0, sval[0]}, 32'd1);
    arst = 1'b1;
    #1;
    chk("rst_mid_val", {31'd0, sval[0]}, 32'd0);
    chk("rst_mid_data", {31'd0, a_sd}, 32'd0);
    chk("rst_mid_mask", {31'd0, a_sm}, 32'd0);
    chk("rst_mid_last", {31'd0, slast[0]}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_mid_rdy", {31'd0, rdy[0]}, 32'd1);
    chk("rst_flushed", qsize(0), 0);
    @(posedge clk);
    @(posedge clk); #1;
    arst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_idle_busy", {31'd0, busy[0]}, 32'd0);
    push_bits(0, 16'b10, 2);
    offer_run(0, 16'h8001, 4'd2, 2, "post_rst");

    repeat (2) @(posedge clk);
    #1;
    chk("drain_q0", qsize(0), 0);
    chk("drain_q1", qsize(1), 0);
    chk("drain_q2", qsize(2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
